// File: rtl/transconv2d_mc_if.sv
// Pixel stream handshake between the pixel loader and the transposed-convolution engine.
interface transconv2d_mc_if #(
  parameter int unsigned pixel_bits = 8
) ();
  logic                  pix_valid;
  logic                  pix_ready;
  logic [pixel_bits-1:0] pixel;

  modport master (output pix_valid, output pixel, input pix_ready);
  modport slave  (input pix_valid, input pixel, output pix_ready);
endinterface

// File: rtl/transconv2d_mc.sv
// Multi-channel runtime-stride 2D transposed convolution engine.
// Each accepted pixel is scattered over a KxK window of an on-chip accumulator map.
module transconv2d_mc #(
  parameter int unsigned N          = 4,
  parameter int unsigned K          = 3,
  parameter int unsigned C          = 2,
  parameter int unsigned pixel_bits = 8,
  parameter int unsigned ACC_BITS   = 24,
  localparam int unsigned D         = N * K,
  localparam int unsigned SW        = $clog2(K) + 1,
  localparam int unsigned AW        = $clog2(D * D),
  localparam int unsigned DW        = $clog2(D) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [SW-1:0]         stride_i,
  input  logic                  w_strobe_i,
  input  logic [pixel_bits-1:0] kernel_weight_i,
  transconv2d_mc_if.slave       pix_if,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [ACC_BITS-1:0]   rd_data_o,
  output logic [pixel_bits-1:0] rd_data_sat_o,
  output logic [DW-1:0]         out_dim_o,
  output logic                  cfg_err_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned DD      = D * D;
  localparam int unsigned NW      = C * K * K;
  localparam int unsigned WIW     = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned RW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KW      = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CW      = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned PW      = 2 * pixel_bits;
  localparam int unsigned SAT_MAX = (1 << pixel_bits) - 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCEPT, S_MAC, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WIW-1:0]        wcnt_q, wcnt_d;
  logic                  wok_q, wok_d;
  logic [AW-1:0]         clr_q, clr_d;
  logic [SW-1:0]         s_q, s_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DW-1:0]         out_dim_q, out_dim_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [RW-1:0]         r_q, r_d, c_q, c_d;
  logic [KW-1:0]         kr_q, kr_d, kc_q, kc_d;
  logic [pixel_bits-1:0] pix_q, pix_d;
  logic [ACC_BITS-1:0]   rd_data_q, rd_data_d;
  logic [pixel_bits-1:0] rd_sat_q, rd_sat_d;
  logic                  busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic [pixel_bits-1:0] w_q [NW];
  logic [ACC_BITS-1:0]   buf_q [DD];

  logic                  buf_we;
  logic [AW-1:0]         buf_waddr;
  logic [ACC_BITS-1:0]   buf_wdata;

  logic                  stride_bad;
  logic [SW-1:0]         s_eff;
  logic [31:0]           mac_row, mac_col;
  logic [AW-1:0]         mac_addr;
  logic [WIW-1:0]        w_idx;
  logic [PW-1:0]         prod;
  logic [ACC_BITS-1:0]   rd_word;
  logic [pixel_bits-1:0] rd_sat;
  logic                  last_pix;

  // Illegal strides fall back to 1 and are flagged.
  assign stride_bad = (stride_i == '0) || (32'(stride_i) > K);
  assign s_eff      = stride_bad ? SW'(1) : stride_i;

  assign mac_row  = 32'(r_q) * 32'(s_q) + 32'(kr_q);
  assign mac_col  = 32'(c_q) * 32'(s_q) + 32'(kc_q);
  assign mac_addr = AW'(mac_row * D + mac_col);
  assign w_idx    = WIW'(32'(ch_q) * (K * K) + 32'(kr_q) * K + 32'(kc_q));
  assign prod     = PW'(pix_q) * PW'(w_q[w_idx]);
  assign last_pix = (ch_q == CW'(C - 1)) && (r_q == RW'(N - 1)) && (c_q == RW'(N - 1));

  assign rd_word = (32'(rd_addr_i) < DD) ? buf_q[rd_addr_i] : '0;
  assign rd_sat  = (rd_word > ACC_BITS'(SAT_MAX)) ? '1 : pixel_bits'(rd_word);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wok_d     = wok_q;
    clr_d     = clr_q;
    s_d       = s_q;
    cfg_err_d = cfg_err_q;
    out_dim_d = out_dim_q;
    ch_d      = ch_q;
    r_d       = r_q;
    c_d       = c_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    pix_d     = pix_q;
    rd_data_d = rd_data_q;
    rd_sat_d  = rd_sat_q;
    buf_we    = 1'b0;
    buf_waddr = clr_q;
    buf_wdata = '0;

    // Readback is live only while the buffer is not being modified.
    if (state_q == S_IDLE || state_q == S_DONE) begin
      rd_data_d = rd_word;
      rd_sat_d  = rd_sat;
    end

    case (state_q)
      S_IDLE: begin
        if (w_strobe_i) begin
          if (wcnt_q == WIW'(NW - 1)) begin
            wcnt_d = '0;
            wok_d  = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        if (enable_i && wok_q) begin
          state_d   = S_CLEAR;
          clr_d     = '0;
          s_d       = s_eff;
          cfg_err_d = stride_bad;
          out_dim_d = DW'((N - 1) * 32'(s_eff) + K);
          ch_d      = '0;
          r_d       = '0;
          c_d       = '0;
        end
      end
      S_CLEAR: begin
        buf_we    = 1'b1;
        buf_waddr = clr_q;
        if (clr_q == AW'(DD - 1)) begin
          state_d = S_ACCEPT;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      S_ACCEPT: begin
        if (pix_if.pix_valid && ready_q) begin
          pix_d   = pix_if.pixel;
          kr_d    = '0;
          kc_d    = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        buf_we    = 1'b1;
        buf_waddr = mac_addr;
        buf_wdata = buf_q[mac_addr] + ACC_BITS'(prod);
        if (kc_q == KW'(K - 1)) begin
          kc_d = '0;
          if (kr_q == KW'(K - 1)) begin
            kr_d    = '0;
            state_d = last_pix ? S_DONE : S_ACCEPT;
            // Advance to the next pixel position in channel-major raster order.
            if (c_q == RW'(N - 1)) begin
              c_d = '0;
              if (r_q == RW'(N - 1)) begin
                r_d  = '0;
                ch_d = ch_q + 1'b1;
              end else begin
                r_d = r_q + 1'b1;
              end
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_CLEAR) || (state_d == S_ACCEPT) || (state_d == S_MAC);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      wok_q     <= 1'b0;
      clr_q     <= '0;
      s_q       <= SW'(1);
      cfg_err_q <= 1'b0;
      out_dim_q <= DW'(N + K - 1);
      ch_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      pix_q     <= '0;
      rd_data_q <= '0;
      rd_sat_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wok_q     <= wok_d;
      clr_q     <= clr_d;
      s_q       <= s_d;
      cfg_err_q <= cfg_err_d;
      out_dim_q <= out_dim_d;
      ch_q      <= ch_d;
      r_q       <= r_d;
      c_q       <= c_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      pix_q     <= pix_d;
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Storage arrays carry no reset; weights_ok and CLEAR guard their contents.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE && w_strobe_i) begin
      w_q[wcnt_q] <= kernel_weight_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && buf_we) begin
      buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign pix_if.pix_ready = ready_q;
  assign rd_data_o        = rd_data_q;
  assign rd_data_sat_o    = rd_sat_q;
  assign out_dim_o        = out_dim_q;
  assign cfg_err_o        = cfg_err_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_transconv2d_mc.sv
// Randomized bench for transconv2d_mc against a loop-level scatter model of the output map.
module tb_transconv2d_mc;

  localparam int unsigned N       = 2;
  localparam int unsigned K       = 3;
  localparam int unsigned C       = 2;
  localparam int unsigned PB      = 8;
  localparam int unsigned AB      = 24;
  localparam int unsigned D       = N * K;
  localparam int unsigned DD      = D * D;
  localparam int unsigned NW      = C * K * K;
  localparam int unsigned NP      = C * N * N;
  localparam int unsigned SW      = $clog2(K) + 1;
  localparam int unsigned AW      = $clog2(DD);
  localparam int unsigned DW      = $clog2(D) + 1;
  localparam int unsigned RUN_CYC = DD + NP * (1 + K * K);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_i;
  logic [SW-1:0] stride_i;
  logic          w_strobe_i;
  logic [PB-1:0] kernel_weight_i;
  logic [AW-1:0] rd_addr_i;
  logic [AB-1:0] rd_data_o;
  logic [PB-1:0] rd_data_sat_o;
  logic [DW-1:0] out_dim_o;
  logic          cfg_err_o;
  logic          busy_o;
  logic          done_o;

  transconv2d_mc_if #(.pixel_bits(PB)) pix_if ();

  transconv2d_mc #(
    .N(N), .K(K), .C(C), .pixel_bits(PB), .ACC_BITS(AB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable_i),
    .stride_i        (stride_i),
    .w_strobe_i      (w_strobe_i),
    .kernel_weight_i (kernel_weight_i),
    .pix_if          (pix_if),
    .rd_addr_i       (rd_addr_i),
    .rd_data_o       (rd_data_o),
    .rd_data_sat_o   (rd_data_sat_o),
    .out_dim_o       (out_dim_o),
    .cfg_err_o       (cfg_err_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  int unsigned       n_checks;
  int unsigned       n_errors;
  int unsigned       wts [NW];
  int unsigned       pix [NP];
  longint unsigned   exp_acc [DD];

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned eff_stride(input int unsigned s);
    return (s == 0 || s > K) ? 1 : s;
  endfunction

  // Scatter every input pixel times its channel's kernel into the output map.
  task automatic build_model(input int unsigned s);
    int unsigned se;
    longint unsigned mask;
    se   = eff_stride(s);
    mask = (64'd1 << AB) - 1;
    for (int a = 0; a < DD; a++) exp_acc[a] = 0;
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++) begin
              int unsigned oy, ox;
              oy = r * se + kr;
              ox = c * se + kc;
              exp_acc[oy * D + ox] = (exp_acc[oy * D + ox]
                + longint'(pix[ch * N * N + r * N + c]) * longint'(wts[ch * K * K + kr * K + kc])) & mask;
            end
  endtask

  task automatic load_weights(input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) begin
      @(negedge clk);
      w_strobe_i      = 1'b1;
      kernel_weight_i = PB'(wts[i]);
    end
    @(negedge clk);
    w_strobe_i = 1'b0;
  endtask

  task automatic read_addr(input int unsigned a, output longint unsigned d, output longint unsigned s);
    rd_addr_i = AW'(a);
    @(negedge clk);
    d = rd_data_o;
    s = rd_data_sat_o;
  endtask

  task automatic check_map(input string tag);
    longint unsigned d, s;
    for (int unsigned a = 0; a < DD; a++) begin
      read_addr(a, d, s);
      check_eq($sformatf("%s rd_data[%0d]", tag, a), d, exp_acc[a]);
      check_eq($sformatf("%s rd_sat[%0d]", tag, a), s, (exp_acc[a] > 255) ? 255 : exp_acc[a]);
    end
  endtask

  // Start a run, stream all pixels and wait (bounded) for done.
  task automatic run_conv(input string tag, input int unsigned s, input bit rand_valid);
    int unsigned cyc, pi, bad_ready, since_hs;
    bit hs;
    @(negedge clk);
    enable_i         = 1'b1;
    stride_i         = SW'(s);
    pix_if.pix_valid = 1'b0;
    cyc = 0; pi = 0; bad_ready = 0; since_hs = 1000; hs = 1'b0;
    do begin
      @(posedge clk);
      if (hs) begin
        pi++;
        since_hs = 0;
      end else if (since_hs < 1000) begin
        since_hs++;
      end
      @(negedge clk);
      cyc++;
      if (pix_if.pix_ready && since_hs < K * K) bad_ready++;
      if (cyc == 2) stride_i = SW'($urandom_range(0, 7));
      hs = 1'b0;
      if (pi < NP) begin
        pix_if.pix_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_if.pixel     = pix_if.pix_valid ? PB'(pix[pi]) : PB'($urandom_range(0, 255));
        hs               = pix_if.pix_valid && pix_if.pix_ready;
      end else begin
        pix_if.pix_valid = 1'b0;
      end
    end while (!done_o && cyc < 4000);
    pix_if.pix_valid = 1'b0;
    check_eq({tag, " done"}, done_o, 1);
    check_eq({tag, " pixels taken"}, pi, NP);
    check_eq({tag, " ready during mac"}, bad_ready, 0);
    if (!rand_valid) check_eq({tag, " latency"}, cyc - 1, RUN_CYC);
  endtask

  task automatic do_run(input string tag, input int unsigned s, input bit rand_valid);
    run_conv(tag, s, rand_valid);
    build_model(s);
    check_eq({tag, " out_dim"}, out_dim_o, (N - 1) * eff_stride(s) + K);
    check_eq({tag, " cfg_err"}, cfg_err_o, (s == 0 || s > K) ? 1 : 0);
    check_eq({tag, " busy in done"}, busy_o, 0);
    check_map(tag);
    check_eq({tag, " done hold"}, done_o, 1);
    enable_i = 1'b0;
    @(negedge clk);
    check_eq({tag, " done cleared"}, done_o, 0);
    check_eq({tag, " idle busy"}, busy_o, 0);
  endtask

  task automatic set_plan_data();
    int unsigned w0 [9] = '{1, 0, 0, 1, 2, 0, 0, 0, 3};
    int unsigned p0 [4] = '{1, 3, 0, 2};
    for (int i = 0; i < NW; i++) wts[i] = (i < 9) ? w0[i] : 0;
    for (int i = 0; i < NP; i++) pix[i] = (i < 4) ? p0[i] : 0;
  endtask

  task automatic set_random_data();
    for (int i = 0; i < NW; i++) wts[i] = $urandom_range(0, 255);
    for (int i = 0; i < NP; i++) pix[i] = $urandom_range(0, 255);
  endtask

  task automatic read_const(input string tag, input int unsigned a, input longint unsigned exp);
    longint unsigned d, s;
    read_addr(a, d, s);
    check_eq(tag, d, exp);
  endtask

  initial begin
    int unsigned cyc;
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    enable_i         = 1'b0;
    stride_i         = '0;
    w_strobe_i       = 1'b0;
    kernel_weight_i  = '0;
    rd_addr_i        = '0;
    pix_if.pix_valid = 1'b0;
    pix_if.pixel     = '0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", busy_o, 0);
    check_eq("reset done", done_o, 0);
    check_eq("reset ready", pix_if.pix_ready, 0);
    check_eq("reset cfg_err", cfg_err_o, 0);
    check_eq("reset rd_data", rd_data_o, 0);
    check_eq("reset rd_sat", rd_data_sat_o, 0);
    check_eq("reset out_dim", out_dim_o, N + K - 1);
    rst = 1'b0;

    // Incomplete weight set must not start a run.
    set_plan_data();
    load_weights(0, NW - 2);
    @(negedge clk);
    enable_i = 1'b1;
    stride_i = SW'(1);
    repeat (5) @(negedge clk);
    check_eq("partial weights busy", busy_o, 0);
    check_eq("partial weights done", done_o, 0);
    enable_i = 1'b0;
    load_weights(NW - 1, NW - 1);

    do_run("s1", 1, 1'b0);
    read_const("s1 addr7", 7, 7);
    read_const("s1 addr15", 15, 9);
    read_const("s1 addr21", 21, 6);

    do_run("s2", 2, 1'b1);
    read_const("s2 addr14", 14, 5);
    read_const("s2 addr28", 28, 6);
    read_const("s2 addr16", 16, 9);

    do_run("s0", 0, 1'b0);
    do_run("s4", 4, 1'b1);

    // Two full-scale channels summed at the origin exceed the 8-bit view.
    for (int i = 0; i < NW; i++) wts[i] = 0;
    wts[0]     = 255;
    wts[K * K] = 255;
    for (int i = 0; i < NP; i++) pix[i] = 255;
    load_weights(0, NW - 1);
    do_run("sat", 1, 1'b0);
    read_const("sat addr0", 0, 130050);
    check_eq("sat addr0 view", rd_data_sat_o, 255);

    for (int it = 0; it < 4; it++) begin
      set_random_data();
      load_weights(0, NW - 1);
      do_run($sformatf("rnd%0d", it), $urandom_range(1, K), 1'b1);
    end

    // Reset in the middle of a MAC burst drops the weight set.
    set_random_data();
    load_weights(0, NW - 1);
    @(negedge clk);
    enable_i         = 1'b1;
    stride_i         = SW'(2);
    pix_if.pix_valid = 1'b1;
    pix_if.pixel     = PB'(pix[0]);
    cyc = 0;
    while (!pix_if.pix_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach accept", pix_if.pix_ready, 1);
    @(negedge clk);
    pix_if.pix_valid = 1'b0;
    @(negedge clk);
    check_eq("mac ready low", pix_if.pix_ready, 0);
    check_eq("mac busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid rst busy", busy_o, 0);
    check_eq("mid rst done", done_o, 0);
    check_eq("mid rst ready", pix_if.pix_ready, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("no reload busy", busy_o, 0);
    enable_i = 1'b0;
    load_weights(0, NW - 1);
    do_run("post rst", 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
